// File: rtl/mult_div_seq_pkg.sv
// mult_div_seq_pkg: shared FSM encoding, op codes and iteration constants for mult_div_seq
package mult_div_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FINISH, ZERO} state_t;
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam int ITERATIONS = 32;
    localparam int CNT_W = 6;
    function automatic logic [31:0] mag(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction
endpackage

// File: rtl/mult_div_seq.sv
// mult_div_seq: sequential signed 32x32 Booth multiplier / restoring divider writing HI/LO
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   start, op, a_in, b_in   request (sampled in IDLE), 0=MULT 1=DIV, signed operands
//   busy, done, div0        in-progress flag, completion pulse, divide-by-zero pulse
//   hilo_write, hi_out, lo_out  HI/LO write strobe and registered results
module mult_div_seq
    import mult_div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic        hilo_write,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);
    state_t state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [32:0] acc_q, acc_d, sum, rsh;
    logic [31:0] q_q, q_d, m_q, hi_d, lo_d;
    logic q1_q, q1_d, op_q, sa_q, sb_q, ge;
    // acc is one bit wider than the operands so Booth add/sub with -2^31 cannot overflow
    // and the divider's shifted remainder always fits
    always_comb begin
        sum = ({q_q[0], q1_q} == 2'b01) ? acc_q + {m_q[31], m_q} :
              ({q_q[0], q1_q} == 2'b10) ? acc_q - {m_q[31], m_q} : acc_q;
        rsh = {acc_q[31:0], q_q[31]};
        ge = rsh >= {1'b0, m_q};
        acc_d = (op_q == OP_MULT) ? {sum[32], sum[32:1]} : (ge ? rsh - {1'b0, m_q} : rsh);
        q_d = (op_q == OP_MULT) ? {sum[0], q_q[31:1]} : {q_q[30:0], ge};
        q1_d = (op_q == OP_MULT) ? q_q[0] : q1_q;
        // divider works on magnitudes; quotient sign is the xor, remainder follows the dividend
        hi_d = (op_q == OP_MULT) ? acc_d[31:0] : (sa_q ? -acc_d[31:0] : acc_d[31:0]);
        lo_d = (op_q == OP_MULT) ? q_d : ((sa_q ^ sb_q) ? -q_d : q_d);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            q_q <= '0;
            m_q <= '0;
            q1_q <= 1'b0;
            op_q <= 1'b0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            div0 <= 1'b0;
            hilo_write <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            hilo_write <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    cnt_q <= '0;
                    acc_q <= '0;
                    q1_q <= 1'b0;
                    op_q <= op;
                    sa_q <= a_in[31];
                    sb_q <= b_in[31];
                    q_q <= (op == OP_DIV) ? mag(a_in) : b_in;
                    m_q <= (op == OP_DIV) ? mag(b_in) : a_in;
                    busy <= 1'b1;
                    if (op == OP_DIV && b_in == '0) begin
                        state_q <= ZERO;
                        done <= 1'b1;
                        div0 <= 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    q_q <= q_d;
                    q1_q <= q1_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
                        state_q <= FINISH;
                        done <= 1'b1;
                        hilo_write <= 1'b1;
                        hi_out <= hi_d;
                        lo_out <= lo_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: directed self-checking bench for mult_div_seq
module tb_mult_div_seq;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0;
    logic [31:0] a_in = '0, b_in = '0;
    logic busy, done, div0, hilo_write;
    logic [31:0] hi_out, lo_out;
    int n_cmp = 0, n_bad = 0;

    mult_div_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .div0(div0), .hilo_write(hilo_write),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    // lat = cycle index relative to the accept cycle N (1 = first cycle after the accepting edge)
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 45) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({busy, done, div0, hilo_write} !== 4'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, div0, hilo_write});
        end
        n_cmp++;
        if ({hi_out, lo_out} !== 64'h0) begin
            n_bad++; $display("FAIL reset_hilo: got %h want 0", {hi_out, lo_out});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        run_op(o, a, b, lat);
        n_cmp++;
        if (lat !== 33) begin
            n_bad++; $display("FAIL %s latency: got %0d want 33", tag, lat);
        end
        n_cmp++;
        if ({hi_out, lo_out} !== {ehi, elo}) begin
            n_bad++; $display("FAIL %s result: got %h_%h want %h_%h", tag, hi_out, lo_out, ehi, elo);
        end
        n_cmp++;
        if ({busy, hilo_write, div0} !== 3'b110) begin
            n_bad++; $display("FAIL %s finish_flags: got %b want 110", tag, {busy, hilo_write, div0});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done, hilo_write} !== 3'b000) begin
            n_bad++; $display("FAIL %s idle_flags: got %b want 000", tag, {busy, done, hilo_write});
        end
    endtask

    task automatic test_div0();
        int lat;
        test_op("preload", 1'b1, 32'h0ACF1234, 32'h00002000, 32'h00001234, 32'h00005678);
        run_op(1'b1, 32'd5, 32'd0, lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++; $display("FAIL div0 latency: got %0d want 1", lat);
        end
        n_cmp++;
        if ({busy, done, div0, hilo_write} !== 4'b1110) begin
            n_bad++; $display("FAIL div0 flags: got %b want 1110", {busy, done, div0, hilo_write});
        end
        n_cmp++;
        if ({hi_out, lo_out} !== 64'h00001234_00005678) begin
            n_bad++; $display("FAIL div0 hilo_hold: got %h_%h want 00001234_00005678", hi_out, lo_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done, div0} !== 3'b000) begin
            n_bad++; $display("FAIL div0 after: got %b want 000", {busy, done, div0});
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd3; b_in = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (4) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        n_cmp++;
        if ({busy, div0, done} !== 3'b100) begin
            n_bad++; $display("FAIL ignore flags: got %b want 100", {busy, div0, done});
        end
        while (!done && lat < 45) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (lat !== 33) begin
            n_bad++; $display("FAIL ignore latency: got %0d want 33", lat);
        end
        n_cmp++;
        if ({hi_out, lo_out, div0} !== {64'd15, 1'b0}) begin
            n_bad++; $display("FAIL ignore result: got %h_%h div0=%b want 0_f div0=0", hi_out, lo_out, div0);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL ignore not_queued: got %b want 00", {busy, done});
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd7; b_in = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({hi_out, lo_out} !== 64'h0) begin
            n_bad++; $display("FAIL midreset hilo: got %h_%h want 0", hi_out, lo_out);
        end
        n_cmp++;
        if ({busy, done, div0, hilo_write} !== 4'b0) begin
            n_bad++; $display("FAIL midreset flags: got %b want 0000", {busy, done, div0, hilo_write});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({done, hilo_write, busy} !== 3'b000) begin
                n_bad++; $display("FAIL midreset no_pulse: got %b want 000", {done, hilo_write, busy});
            end
        end
        test_op("div100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
    endtask

    initial begin
        test_reset();
        test_op("mul7xm3", 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        test_op("mulmin", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        test_op("mulm5x6", 1'b0, 32'hFFFFFFFB, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFE2);
        test_op("divm7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_op("divwrap", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        test_op("div100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);
        test_op("divm100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);
        test_div0();
        test_op("b2b_after_div0", 1'b0, 32'hFFFFFFFB, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFE2);
        test_ignore_start();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 SHALL provide: clk  in  1  system clock; all state changes on the rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: start  in  1  request a new operation; sampled only in IDLE.
REQ-004 SHALL provide: op  in  1  operation select, 0 = MULT, 1 = DIV (Div_Mult_Ctrl).
REQ-005 SHALL provide: a_in  in  32  signed multiplicand or dividend.
REQ-006 SHALL provide: b_in  in  32  signed multiplier or divisor.
REQ-007 SHALL provide: busy  out  1  high from the cycle after accepted start until the cycle after completion.
REQ-008 SHALL provide: done  out  1  single-cycle completion pulse.
REQ-009 SHALL provide: div0  out  1  single-cycle divide-by-zero pulse (DIV0), coincident with done.
REQ-010 SHALL provide: hilo_write  out  1  single-cycle HI/LO write enable (write).
REQ-011 SHALL provide: hi_out  out  32  HI result; product[63:32] or remainder.
REQ-012 SHALL provide: lo_out  out  32  LO result; product[31:0] or quotient.

Function
REQ-013 SHALL implement states IDLE, RUN, FINISH, ZERO.
REQ-014 In IDLE with start=1, SHALL latch a_in, b_in and op and clear the iteration counter on that edge (cycle N).
REQ-015 If op=DIV and b_in=0 at start, SHALL go to ZERO; else SHALL go to RUN.
REQ-016 RUN SHALL perform exactly 32 iterations, cycles N+1..N+32 (6-bit counter 0..31), then go to FINISH.
REQ-017 MULT: radix-2 Booth, signed 32x32 -> 64-bit product; no overflow indication.
REQ-018 DIV: restoring on magnitudes, with signs fixed up in FINISH; quotient truncates toward zero; remainder takes the dividend's sign.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo_out=0x80000000, hi_out=0 (wrap), with no div0.
REQ-020 FINISH (cycle N+33): hi_out/lo_out registered valid, done=1, hilo_write=1; next state IDLE.
REQ-021 ZERO (cycle N+1): done=1, div0=1, hilo_write=0, hi_out/lo_out unchanged; next state IDLE.
REQ-022 hi_out/lo_out SHALL hold their last value except at a FINISH update or reset.
REQ-023 start while not in IDLE SHALL be ignored; it is not queued, and a_in/b_in changes SHALL NOT affect the operation in progress.
REQ-024 Back-to-back: start asserted in the IDLE cycle right after FINISH/ZERO SHALL be accepted; minimum issue interval 34 cycles (MULT/DIV), 2 cycles (div0).
REQ-025 done, div0 and hilo_write SHALL never be high outside FINISH/ZERO.

Reset
REQ-026 reset SHALL force IDLE and clear busy, done, div0, hilo_write, hi_out, lo_out, counter and operand registers immediately, independent of clk.
REQ-027 reset mid-RUN SHALL abort the operation with no done or hilo_write pulse; the first start after release SHALL behave as REQ-014.

Structure
REQ-028 Shared package SHALL hold the state encoding, OP_MULT=1'b0/OP_DIV=1'b1, ITERATIONS=32 and the counter width 6.
REQ-029 SHALL be a single module: FSM plus shift/add/sub datapath inline; no sub-module.

Verification
REQ-030 MULT 7 x 0xFFFFFFFD -> at N+33: hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, done=hilo_write=1 for 1 cycle.
REQ-031 MULT 0x80000000 x 0x80000000 -> hi_out=0x40000000, lo_out=0x00000000.
REQ-032 DIV 0xFFFFFFF9 / 2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
REQ-033 DIV 5 / 0 with hi/lo preloaded 0x1234/0x5678 -> at N+1: div0=done=1, hilo_write=0, hi/lo unchanged; busy low at N+2.
REQ-034 MULT started, start re-pulsed at N+5 with new operands, reset asserted at N+10 -> outputs 0 asynchronously, no done; after release, DIV 100/7 -> lo_out=14, hi_out=2 at N'+33.
